// File: rtl/aes_pkg.sv
// Shared AES definitions: word/block types, S-box table, xtime and AES-128 constants.
// Used by the key schedule and by the cipher round datapath.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef enum logic {StIdle, StRun} ks_state_e;

    localparam logic [7:0]  RCON_INIT = 8'h01;
    localparam int unsigned NR_AES128 = 10;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_schedule_if.sv
// Round-key handshake bundle: start/key request in, round keys out under valid/ready.
interface aes128_key_schedule_if;
    import aes_pkg::*;

    logic       start;
    block_t     key;
    logic       busy;
    block_t     rkey;
    logic [3:0] rkey_idx;
    logic       rkey_valid;
    logic       rkey_ready;
    logic       done;

    modport master (
        output start, key, rkey_ready,
        input  busy, rkey, rkey_idx, rkey_valid, done
    );

    modport slave (
        input  start, key, rkey_ready,
        output busy, rkey, rkey_idx, rkey_valid, done
    );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word, purely combinational.
module aes_sub_word
    import aes_pkg::*;
(
    input  word_t word_i,
    output word_t word_o
);
    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_o[8*i +: 8] = sbox(word_i[8*i +: 8]);
    end
endmodule

// File: rtl/aes128_key_schedule.sv
// Iterative AES-128 key expansion: one round key per valid/ready handshake, rounds 0..NR.
// The next key is computed combinationally from the current one in a single cycle.
module aes128_key_schedule
    import aes_pkg::*;
#(
    parameter int unsigned NR    = NR_AES128,
    parameter int unsigned KEY_W = 128
) (
    input logic                  clk_i,
    input logic                  rst_i,
    aes128_key_schedule_if.slave ks
);
    if (NR != NR_AES128 || KEY_W != 128) begin : g_param_check
        $error("aes128_key_schedule supports only NR=10, KEY_W=128");
    end

    localparam logic [3:0] LastIdx = 4'(NR);

    ks_state_e        state_q;
    logic [KEY_W-1:0] key_q;
    logic [3:0]       idx_q;
    logic [7:0]       rcon_q;
    logic             done_q;

    word_t  w0, w1, w2, w3, rot, sub, temp, n0, n1, n2, n3;
    block_t key_next;

    assign {w0, w1, w2, w3} = key_q;
    assign rot = {w3[23:0], w3[31:24]};

    aes_sub_word u_sub_word (
        .word_i (rot),
        .word_o (sub)
    );

    assign temp     = sub ^ {rcon_q, 24'h0};
    assign n0       = w0 ^ temp;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign key_next = {n0, n1, n2, n3};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ks.start) begin
                        key_q   <= ks.key;
                        idx_q   <= '0;
                        rcon_q  <= RCON_INIT;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (ks.rkey_ready) begin
                        if (idx_q == LastIdx) begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            key_q  <= key_next;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= xtime(rcon_q);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are forced to zero outside RUN so nothing stale leaks after reset or completion.
    assign ks.busy       = (state_q == StRun);
    assign ks.rkey_valid = (state_q == StRun);
    assign ks.rkey       = (state_q == StRun) ? key_q : '0;
    assign ks.rkey_idx   = (state_q == StRun) ? idx_q : 4'd0;
    assign ks.done       = done_q;

    function automatic logic [7:0] rcon_expect(input logic [3:0] idx);
        if (idx < 4'd8) return 8'h01 << idx;
        return (idx == 4'd8) ? 8'h1b : 8'h36;
    endfunction

    // rcon_q holds the constant for deriving round idx+1 from round idx.
    rcon_seq_a: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StRun && idx_q < LastIdx) |-> (rcon_q == rcon_expect(idx_q)));

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Self-checking bench for aes128_key_schedule against a word-level FIPS-197 key expansion model.
module tb_aes128_key_schedule;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes128_key_schedule_if ks_if ();

    aes128_key_schedule dut (
        .clk_i (clk),
        .rst_i (rst),
        .ks    (ks_if.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    block_t     exp_rk  [0:10];
    block_t     kv      [0:10];
    bit         kv_mask [0:10];
    logic [7:0] ref_sb  [256];

    localparam block_t KeyA1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam block_t KeyZero = 128'h0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p = 0;
        int x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11b;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        logic [7:0] p   = a;
        int         v, s;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        v = inv;
        s = v;
        for (int n = 1; n <= 4; n++) s = s ^ (((v << n) | (v >> (8 - n))) & 255);
        s = s ^ 'h63;
        return s[7:0];
    endfunction

    task automatic model_expand(input block_t key);
        word_t      w [44];
        word_t      t;
        logic [7:0] rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {ref_sb[t[31:24]], ref_sb[t[23:16]], ref_sb[t[15:8]], ref_sb[t[7:0]]};
                t  = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic start_run(input block_t key);
        model_expand(key);
        @(negedge clk);
        ks_if.start = 1'b1;
        ks_if.key   = key;
    endtask

    // Walks one run; stops early (before handshaking) once round stop_at is observed.
    task automatic collect(input int stall, input bit inject, input int stop_at);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        while (k < 11 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check_eq("valid", ks_if.rkey_valid, 1);
            check_eq("busy", ks_if.busy, 1);
            check_eq("idx", ks_if.rkey_idx, k);
            check_eq($sformatf("rkey%0d", k), ks_if.rkey, exp_rk[k]);
            if (kv_mask[k]) check_eq($sformatf("vector%0d", k), ks_if.rkey, kv[k]);
            check_eq("done_low", ks_if.done, 0);
            if (k == stop_at) return;
            rdy = ($urandom_range(99) >= stall);
            ks_if.rkey_ready = rdy;
            ks_if.start = inject && (k < 10) && ($urandom_range(1) == 1);
            ks_if.key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (rdy) k++;
        end
        if (k < 11) check_eq("timeout", k, 11);
        else if (stall == 0) check_eq("latency", cyc, 11);
    endtask

    task automatic finish_run(input bit restart, input block_t nkey);
        @(negedge clk);
        check_eq("done_pulse", ks_if.done, 1);
        check_eq("busy_end", ks_if.busy, 0);
        check_eq("valid_end", ks_if.rkey_valid, 0);
        ks_if.rkey_ready = 1'b0;
        if (restart) begin
            ks_if.start = 1'b1;
            ks_if.key   = nkey;
        end else begin
            @(negedge clk);
            check_eq("done_once", ks_if.done, 0);
        end
    endtask

    task automatic set_vectors(input bit zero_key);
        for (int i = 0; i < 11; i++) kv_mask[i] = 1'b0;
        if (zero_key) begin
            kv[1]  = 128'h62636363626363636263636362636363;
            kv[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        end else begin
            kv[0]  = KeyA1;
            kv[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            kv[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
            kv[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            kv_mask[0] = 1'b1;
            kv_mask[2] = 1'b1;
        end
        kv_mask[1]  = 1'b1;
        kv_mask[10] = 1'b1;
    endtask

    task automatic clear_vectors();
        for (int i = 0; i < 11; i++) kv_mask[i] = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, ks_if.rkey_valid, 0);
        check_eq({tag, "_busy"}, ks_if.busy, 0);
        check_eq({tag, "_done"}, ks_if.done, 0);
        check_eq({tag, "_idx"}, ks_if.rkey_idx, 0);
        check_eq({tag, "_rkey"}, ks_if.rkey, 0);
    endtask

    initial begin
        ks_if.start      = 1'b0;
        ks_if.key        = '0;
        ks_if.rkey_ready = 1'b0;
        for (int i = 0; i < 256; i++) ref_sb[i] = ref_sbox_calc(8'(i));
        clear_vectors();

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("idle");

        // FIPS-197 A.1 key, no backpressure
        set_vectors(1'b0);
        start_run(KeyA1);
        collect(0, 1'b0, -1);
        finish_run(1'b0, '0);

        // Same key with ~50% stalls
        start_run(KeyA1);
        collect(50, 1'b0, -1);
        finish_run(1'b0, '0);

        // start toggled mid-run, then restart in the done cycle
        start_run(KeyA1);
        collect(30, 1'b1, -1);
        model_expand(KeyA1);
        finish_run(1'b1, KeyA1);
        collect(0, 1'b0, -1);
        finish_run(1'b0, '0);

        // Reset at round 5, then a clean rerun
        start_run(KeyA1);
        collect(0, 1'b0, 5);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("midrst");
        rst = 1'b0;
        start_run(KeyA1);
        collect(0, 1'b0, -1);
        finish_run(1'b0, '0);

        // All-zero key
        set_vectors(1'b1);
        start_run(KeyZero);
        collect(0, 1'b0, -1);
        finish_run(1'b0, '0);

        // Random keys with random backpressure
        clear_vectors();
        for (int r = 0; r < 8; r++) begin
            start_run({$urandom(), $urandom(), $urandom(), $urandom()});
            collect(50, (r % 2) == 1, -1);
            finish_run(1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
